// File: rtl/roll_scheduler_pkg.sv
// Purpose : shared constants and state encoding for the rolling 7-segment sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: CODE_W (character code width), CODE_BLANK (code that lights no segment),
// DEF_NUM_DIGITS (default digit count), state_t (IDLE / RUN).
package roll_pkg;

   localparam int CODE_W         = 5;
   localparam int CODE_BLANK     = 0;
   localparam int DEF_NUM_DIGITS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/roll_scheduler_tick_divider.sv
// Purpose : modulo-DIV counter emitting a one-cycle strobe at terminal count.
// Latency : o_tick is combinational from the count; first tick DIV cycles after clear.
// Backpressure: none; i_en pauses counting, i_clr forces count to 0 and masks the tick.
//
// Ports: i_clk, i_rst (async, active-high), i_clr (sync clear), i_en (count enable),
//        o_tick (high for the one cycle the count sits at DIV-1 while enabled).
module tick_divider #(
   parameter int DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // A clear in the same cycle as terminal count wins, so a restart never
   // sees a stale strobe from the previous run.
   assign o_tick = i_en && !i_clr && (r_cnt == TERM);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/roll_scheduler.sv
// Purpose : holds a message of character codes and time-multiplexes it onto the digits,
//           scrolling the visible window one character per scroll period.
// Latency : o_an/o_code are registered, updating one cycle after the digit/offset change.
// Backpressure: none; writes accepted every cycle, start/stop sampled every cycle.
//
// Ports: i_clk, i_rst (async active-high); i_wr_en/i_wr_addr/i_wr_data message writes;
//        i_msg_len (sampled on start); i_start, i_stop (stop wins);
//        o_code (code for enabled digit), o_an (active-low one-hot), o_busy (RUN),
//        o_wrap (one-cycle pulse when the scroll offset returns to 0).
module roll_scheduler #(
   parameter int NUM_DIGITS  = roll_pkg::DEF_NUM_DIGITS,
   parameter int MSG_DEPTH   = 32,
   parameter int REFRESH_DIV = 100000,
   parameter int SCROLL_DIV  = 50000000,
   parameter int CODE_W      = roll_pkg::CODE_W,
   localparam int AW         = $clog2(MSG_DEPTH),
   localparam int IW         = $clog2(NUM_DIGITS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_en,
   input  logic [AW-1:0]         i_wr_addr,
   input  logic [CODE_W-1:0]     i_wr_data,
   input  logic [AW:0]           i_msg_len,
   input  logic                  i_start,
   input  logic                  i_stop,
   output logic [CODE_W-1:0]     o_code,
   output logic [NUM_DIGITS-1:0] o_an,
   output logic                  o_busy,
   output logic                  o_wrap
);

   import roll_pkg::*;

   localparam logic [CODE_W-1:0] BLANK      = CODE_W'(CODE_BLANK);
   localparam logic [AW:0]       LEN_DIGITS = (AW+1)'(NUM_DIGITS);
   localparam logic [AW:0]       LEN_MAX    = (AW+1)'(MSG_DEPTH);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(NUM_DIGITS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_restart;
   logic                w_start_ok;
   logic                w_div_clr;
   logic                w_run;
   logic                w_scroll_en;
   logic                w_ref_tick;
   logic                w_scr_tick;
   logic [AW:0]         r_len_q;
   logic [AW:0]         w_len_m1;
   logic [AW-1:0]       r_offset;
   logic [IW-1:0]       r_idx;
   logic                r_load;
   logic                r_wrap;
   logic [AW:0]         w_p;
   logic [AW:0]         w_p_mod;
   logic [AW-1:0]       w_rd_addr;
   logic [CODE_W-1:0]   w_sel_code;
   logic [CODE_W-1:0]   r_mem [MSG_DEPTH];

   // ---------------- control FSM ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_start_ok  = i_start && (i_msg_len != '0) && (i_msg_len <= LEN_MAX);
      if (i_stop) begin
         w_state_nxt = IDLE;
      end else if (w_start_ok) begin
         // Covers both IDLE->RUN and restart while already running.
         w_state_nxt = RUN;
         w_restart   = 1'b1;
      end
   end

   assign w_run       = (r_state == RUN);
   assign w_div_clr   = w_restart || i_stop || !w_run;
   // Short messages fit on the display, so the window never scrolls.
   assign w_scroll_en = w_run && (r_len_q >= LEN_DIGITS);

   tick_divider #(.DIV(REFRESH_DIV)) u_ref_div (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_div_clr),
      .i_en   (w_run),
      .o_tick (w_ref_tick)
   );

   tick_divider #(.DIV(SCROLL_DIV)) u_scr_div (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_div_clr),
      .i_en   (w_scroll_en),
      .o_tick (w_scr_tick)
   );

   // ---------------- digit index / scroll offset ----------------
   assign w_len_m1 = r_len_q - 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_len_q  <= '0;
         r_offset <= '0;
         r_idx    <= '0;
         r_load   <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         // Output registers reload only when idx or offset just moved, so a
         // write to the displayed address cannot change a digit mid-slot.
         r_load <= w_restart || w_ref_tick || w_scr_tick;
         r_wrap <= 1'b0;
         if (w_restart) begin
            r_len_q  <= i_msg_len;
            r_offset <= '0;
            r_idx    <= '0;
         end else begin
            if (w_ref_tick) begin
               r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_scr_tick) begin
               if ({1'b0, r_offset} == w_len_m1) begin
                  r_offset <= '0;
                  r_wrap   <= 1'b1;
               end else begin
                  r_offset <= r_offset + 1'b1;
               end
            end
         end
      end
   end

   // ---------------- message buffer ----------------
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // ---------------- character select ----------------
   always_comb begin
      w_p        = {1'b0, r_offset} + (AW+1)'(r_idx);
      w_p_mod    = w_p;
      w_rd_addr  = '0;
      w_sel_code = BLANK;
      if (r_len_q >= LEN_DIGITS) begin
         // offset < len and idx < NUM_DIGITS <= len, so one subtraction wraps p.
         if (w_p >= r_len_q) begin
            w_p_mod = w_p - r_len_q;
         end
         w_rd_addr  = AW'(w_p_mod);
         w_sel_code = r_mem[w_rd_addr];
      end else if ((AW+1)'(r_idx) < r_len_q) begin
         w_rd_addr  = AW'(r_idx);
         w_sel_code = r_mem[w_rd_addr];
      end
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_an   <= '1;
         o_code <= BLANK;
      end else if (w_state_nxt == IDLE) begin
         o_an   <= '1;
         o_code <= BLANK;
      end else if (r_load) begin
         o_an   <= ~(NUM_DIGITS'(1) << r_idx);
         o_code <= w_sel_code;
      end
   end

   assign o_busy = w_run;
   assign o_wrap = r_wrap;

endmodule
